// File: rtl/pe_array_collector_pkg.sv
// Shared defaults and FSM encoding for the PE array result collector.
package pe_array_collector_pkg;

  localparam int PE_NUM_DEF     = 8;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DRAIN   = 1'b1
  } state_t;

  // Read index width; a single-slot array still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_array_collector_if.sv
// Collector bus: per-PE result capture side plus the valid/ready overlay output stream.
interface pe_array_collector_if
  import pe_array_collector_pkg::*;
#(
  parameter int PE_NUM     = PE_NUM_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int W = 2 * DATA_WIDTH;

  logic                  load;
  logic [PE_NUM-1:0]     pe_out_v;
  logic [PE_NUM*W-1:0]   pe_out;
  logic                  dout_overlay_v;
  logic [W-1:0]          dout_overlay;
  logic                  dout_last;
  logic                  dout_ready;
  logic                  ovf;

  modport master (
    output load, pe_out_v, pe_out, dout_ready,
    input  dout_overlay_v, dout_overlay, dout_last, ovf
  );

  modport slave (
    input  load, pe_out_v, pe_out, dout_ready,
    output dout_overlay_v, dout_overlay, dout_last, ovf
  );

endinterface

// File: rtl/pe_array_collector_collect_slot.sv
// One collector slot: holds the first word a PE delivers in a frame; clears to 0 when the frame drains.
module collect_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_en,
  input  logic         clr,
  input  logic         vld,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         mask
);

  logic cap;
  assign cap = cap_en & vld & ~mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      mask <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      mask <= 1'b0;
    end else if (cap) begin
      q    <= din;
      mask <= 1'b1;
    end
  end

endmodule

// File: rtl/pe_array_collector.sv
// Collects one word per PE, then streams the frame out in slot order (1 word/cycle, holds under backpressure).
// Optional sticky drop detector on ovf when PE_COLLECT_OVF_EN is defined.
module pe_array_collector
  import pe_array_collector_pkg::*;
#(
  parameter int PE_NUM     = PE_NUM_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_array_collector_if.slave  bus
);

  localparam int W  = 2 * DATA_WIDTH;
  localparam int IW = idx_width(PE_NUM);
  localparam logic [IW-1:0] LAST_IDX = IW'(PE_NUM - 1);

  state_t            state;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     nxt_idx;
  logic [PE_NUM-1:0] mask;
  logic [PE_NUM-1:0] mask_nxt;
  logic [W-1:0]      slot_q [PE_NUM];
  logic              collecting;
  logic              go_drain;
  logic              frame_done;

  assign collecting = (state == ST_COLLECT);
  assign nxt_idx    = rd_idx + IW'(1);
  // Drain decision looks at the mask including this cycle's captures.
  assign mask_nxt   = mask | (bus.pe_out_v & {PE_NUM{collecting}});
  assign go_drain   = collecting & ((&mask_nxt) | (bus.load & (|mask_nxt)));
  assign frame_done = (state == ST_DRAIN) & bus.dout_overlay_v & bus.dout_ready
                    & (rd_idx == LAST_IDX);

  for (genvar k = 0; k < PE_NUM; k++) begin : g_slot
    collect_slot #(.W(W)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .cap_en (collecting),
      .clr    (frame_done),
      .vld    (bus.pe_out_v[k]),
      .din    (bus.pe_out[k*W +: W]),
      .q      (slot_q[k]),
      .mask   (mask[k])
    );
  end

  // rd_idx always names the slot currently held in the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_COLLECT;
      rd_idx             <= '0;
      bus.dout_overlay_v <= 1'b0;
      bus.dout_overlay   <= '0;
      bus.dout_last      <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (go_drain) begin
            state  <= ST_DRAIN;
            rd_idx <= '0;
          end
        end
        ST_DRAIN: begin
          if (!bus.dout_overlay_v) begin
            bus.dout_overlay_v <= 1'b1;
            bus.dout_overlay   <= slot_q[rd_idx];
            bus.dout_last      <= (rd_idx == LAST_IDX);
          end else if (bus.dout_ready) begin
            if (rd_idx == LAST_IDX) begin
              bus.dout_overlay_v <= 1'b0;
              bus.dout_last      <= 1'b0;
              rd_idx             <= '0;
              state              <= ST_COLLECT;
            end else begin
              rd_idx           <= nxt_idx;
              bus.dout_overlay <= slot_q[nxt_idx];
              bus.dout_last    <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

`ifdef PE_COLLECT_OVF_EN
  logic drop;
  assign drop = collecting ? (|(bus.pe_out_v & mask)) : (|bus.pe_out_v);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bus.ovf <= 1'b0;
    else if (drop)
      bus.ovf <= 1'b1;
  end
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pe_array_collector.sv
// Scoreboard bench for pe_array_collector: directed frames, monitor pops expected words on each handshake.
module tb_pe_array_collector;

  localparam int PE_NUM = 8;
  localparam int DW     = 16;
  localparam int W      = 2 * DW;
`ifdef PE_COLLECT_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pe_array_collector_if #(.PE_NUM(PE_NUM), .DATA_WIDTH(DW)) bus ();

  pe_array_collector #(.PE_NUM(PE_NUM), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int ntests = 0;
  int nfail  = 0;
  int vcnt   = 0;
  logic [W:0] exp_q [$];

  logic         held_v = 1'b0;
  logic [W-1:0] held_dat;
  logic         held_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [W-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic capture_one(input int k, input logic [W-1:0] w);
    bus.pe_out_v = '0;
    bus.pe_out_v[k] = 1'b1;
    bus.pe_out[k*W +: W] = w;
    tick();
    bus.pe_out_v = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.dout_overlay_v) && n < 300) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (n >= 300) begin
      nfail++;
      $display("FAIL %s: drain timeout, %0d words still expected", name, exp_q.size());
    end
    tick();
  endtask

  // Monitor: checks hold stability under backpressure and pops on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        ntests++;
        if (!(bus.dout_overlay_v && bus.dout_overlay == held_dat && bus.dout_last == held_last)) begin
          nfail++;
          $display("FAIL hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   bus.dout_overlay_v, bus.dout_overlay, bus.dout_last, held_dat, held_last);
        end
      end
      if (bus.dout_overlay_v) vcnt++;
      if (bus.dout_overlay_v && bus.dout_ready) begin
        ntests++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected word: got d=%0h l=%0b expected none",
                   bus.dout_overlay, bus.dout_last);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          if ({bus.dout_last, bus.dout_overlay} !== e) begin
            nfail++;
            $display("FAIL word: got d=%0h l=%0b expected d=%0h l=%0b",
                     bus.dout_overlay, bus.dout_last, e[W-1:0], e[W]);
          end
        end
        held_v = 1'b0;
      end else if (bus.dout_overlay_v) begin
        held_v    = 1'b1;
        held_dat  = bus.dout_overlay;
        held_last = bus.dout_last;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.load       = 1'b0;
    bus.pe_out_v   = '0;
    bus.pe_out     = '0;
    bus.dout_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid", 64'(bus.dout_overlay_v), 0);
    chk("reset data",  64'(bus.dout_overlay), 0);
    chk("reset last",  64'(bus.dout_last), 0);
    chk("reset ovf",   64'(bus.ovf), 0);
    tick();
    rst = 1'b1;
    tick();

    // Full frame with drain-start timing
    for (int k = 0; k < PE_NUM; k++) exp_push(32'h1000 + k, k == PE_NUM - 1);
    for (int k = 0; k < PE_NUM; k++) capture_one(k, 32'h1000 + k);
    @(negedge clk);
    chk("full: no valid 1 edge after fill", 64'(bus.dout_overlay_v), 0);
    for (int i = 0; i < PE_NUM; i++) begin
      @(negedge clk);
      chk($sformatf("full: valid cycle %0d", i), 64'(bus.dout_overlay_v), 1);
    end
    @(negedge clk);
    chk("full: valid drops after frame", 64'(bus.dout_overlay_v), 0);
    wait_idle("full");
    chk("ovf clean frame", 64'(bus.ovf), 0);

    // Backpressure: ready alternates, first valid cycle sees ready=0
    for (int k = 0; k < PE_NUM; k++) exp_push(32'h2000 + k, k == PE_NUM - 1);
    for (int k = 0; k < PE_NUM; k++) capture_one(k, 32'h2000 + k);
    vcnt = 0;
    tick();
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.dout_ready = ~bus.dout_ready;
    end
    bus.dout_ready = 1'b1;
    wait_idle("backpressure");
    chk("backpressure valid cycles", 64'(vcnt), 16);

    // Early drain of slots 0 and 3
    exp_push(32'hAAAA0000, 1'b0);
    exp_push(32'h0, 1'b0);
    exp_push(32'h0, 1'b0);
    exp_push(32'hBBBB0003, 1'b0);
    exp_push(32'h0, 1'b0);
    exp_push(32'h0, 1'b0);
    exp_push(32'h0, 1'b0);
    exp_push(32'h0, 1'b1);
    capture_one(0, 32'hAAAA0000);
    capture_one(3, 32'hBBBB0003);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_idle("early drain");

    // Duplicate beat in COLLECT, late beat in DRAIN
    for (int k = 0; k < PE_NUM; k++)
      exp_push((k == 2) ? 32'h22 : 32'h30 + k, k == PE_NUM - 1);
    capture_one(2, 32'h22);
    chk("ovf before drop", 64'(bus.ovf), 0);
    capture_one(2, 32'h99);
    chk("ovf after duplicate", 64'(bus.ovf), 64'(EXP_OVF));
    for (int k = 0; k < PE_NUM; k++)
      if (k != 2) capture_one(k, 32'h30 + k);
    capture_one(5, 32'h55);
    wait_idle("duplicate/late");
    chk("ovf sticky", 64'(bus.ovf), 64'(EXP_OVF));

    // All PEs plus load in one cycle
    for (int k = 0; k < PE_NUM; k++) begin
      exp_push(32'h7000 + k, k == PE_NUM - 1);
      bus.pe_out[k*W +: W] = 32'h7000 + k;
    end
    bus.pe_out_v = '1;
    bus.load     = 1'b1;
    tick();
    bus.pe_out_v = '0;
    bus.load     = 1'b0;
    wait_idle("simultaneous");

    // Load with empty mask
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus.dout_overlay_v;
    end
    chk("load on empty mask", 64'(seen), 0);
    tick();

    // Reset after three words of a drain
    for (int k = 0; k < 3; k++) exp_push(32'h8000 + k, 1'b0);
    for (int k = 0; k < PE_NUM; k++) capture_one(k, 32'h8000 + k);
    repeat (4) tick();
    chk("pre-reset valid", 64'(bus.dout_overlay_v), 1);
    chk("pre-reset word 3", 64'(bus.dout_overlay), 64'h8003);
    rst = 1'b0;
    #1;
    chk("async reset valid", 64'(bus.dout_overlay_v), 0);
    chk("async reset data",  64'(bus.dout_overlay), 0);
    chk("scoreboard after 3 words", 64'(exp_q.size()), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("ovf after reset", 64'(bus.ovf), 0);
    for (int k = 0; k < PE_NUM; k++) exp_push(32'h9000 + k, k == PE_NUM - 1);
    for (int k = 0; k < PE_NUM; k++) capture_one(k, 32'h9000 + k);
    wait_idle("post-reset frame");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
